pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage IF/ID/EX/DM/WB core.
- Tracks the destination register of every in-flight instruction in an internal shadow scoreboard, one entry per stage EX/DM/WB.
- From the scoreboard it generates:
  - PC and IF/ID hold (stall);
  - ID/EX bubble;
  - IF/ID and ID/EX flush;
  - EX forwarding selects, latched through ID/EX;
  - ID-stage write-back bypass.
- Also runs the halt-drain FSM and the stall/flush event counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_sb_stage.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: redirect selects,
// halt-drain FSM states and the scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // EX-stage operand redirect selects
  localparam logic [FWD_W-1:0] MUX_EX_REDIR_OLD = 2'd0;
  localparam logic [FWD_W-1:0] MUX_EX_REDIR_EX  = 2'd1;
  localparam logic [FWD_W-1:0] MUX_EX_REDIR_DM  = 2'd2;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } hz_state_e;

  // One in-flight destination: valid is only ever set for a non-zero register
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] req_w;
    logic             is_load;
  } sb_entry_t;

  // True when entry e will write source register src ($0 never matches)
  function automatic logic sb_match(input sb_entry_t e, input logic [REG_W-1:0] src);
    return e.valid && (e.req_w == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// Single scoreboard entry register; advances with the pipeline and can be
// loaded with an invalid entry to model a bubble.
import pipe_hazard_ctrl_pkg::*;

module hazard_sb_stage (
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      clear,
  input  sb_entry_t d,
  output sb_entry_t q
);

  // Entry register: cleared on reset, loads (or empties) on each pipeline step
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (advance) begin
      q <= clear ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: shadow scoreboard of
// in-flight destinations, forwarding/bypass selects, load-use stall, branch
// flush, halt-drain FSM and saturating stall/flush event counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [REG_W-1:0] id_req_a,
  input  logic [REG_W-1:0] id_req_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_w_en,
  input  logic [REG_W-1:0] id_req_w,
  input  logic             id_is_load,
  input  logic             ex_load_pc,
  input  logic             ex_halt,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             wb_byp_a,
  output logic             wb_byp_b,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  hz_state_e         state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  sb_entry_t         id_entry, sb_ex, sb_dm, sb_wb;
  logic              hit_ex_a, hit_ex_b, hit_dm_a, hit_dm_b;
  logic              load_use, lu_stall, halting;
  logic              unused_wb_load;

  assign id_entry = '{valid: id_w_en && (id_req_w != '0), req_w: id_req_w, is_load: id_is_load};
  assign unused_wb_load = sb_wb.is_load;

  hazard_sb_stage u_sb_ex (
    .clk     (clk),
    .rst     (rst),
    .advance (en),
    .clear   (bubble),
    .d       (id_entry),
    .q       (sb_ex)
  );

  hazard_sb_stage u_sb_dm (
    .clk     (clk),
    .rst     (rst),
    .advance (en),
    .clear   (1'b0),
    .d       (sb_ex),
    .q       (sb_dm)
  );

  hazard_sb_stage u_sb_wb (
    .clk     (clk),
    .rst     (rst),
    .advance (en),
    .clear   (1'b0),
    .d       (sb_dm),
    .q       (sb_wb)
  );

  // Forwarding selects and WB bypass; the youngest writer (EX) wins over DM
  always_comb begin
    hit_ex_a = id_use_a && sb_match(sb_ex, id_req_a);
    hit_ex_b = id_use_b && sb_match(sb_ex, id_req_b);
    hit_dm_a = id_use_a && sb_match(sb_dm, id_req_a);
    hit_dm_b = id_use_b && sb_match(sb_dm, id_req_b);
    fwd_a    = hit_ex_a ? MUX_EX_REDIR_EX : (hit_dm_a ? MUX_EX_REDIR_DM : MUX_EX_REDIR_OLD);
    fwd_b    = hit_ex_b ? MUX_EX_REDIR_EX : (hit_dm_b ? MUX_EX_REDIR_DM : MUX_EX_REDIR_OLD);
    wb_byp_a = id_use_a && sb_match(sb_wb, id_req_a);
    wb_byp_b = id_use_b && sb_match(sb_wb, id_req_b);
    load_use = sb_ex.is_load && (hit_ex_a || hit_ex_b);
  end

  // Halt-drain FSM next state plus stall/bubble/flush generation
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    lu_stall = 1'b0;
    halting  = 1'b0;
    unique case (state_q)
      StRun: begin
        // a halting syscall also kills the younger instructions behind it
        flush    = ex_load_pc || ex_halt;
        halting  = ex_halt;
        lu_stall = load_use && !flush;
        stall    = lu_stall;
        bubble   = flush || lu_stall;
        if (ex_halt) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYC);
        end
      end
      StDrain: begin
        flush   = 1'b1;
        bubble  = 1'b1;
        halting = 1'b1;
        if (drain_q <= DrainW'(1)) begin
          state_d = StHalted;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      StHalted: begin
        stall   = 1'b1;
        halting = 1'b1;
      end
      default: state_d = StRun;
    endcase
    // a disabled step freezes everything and suppresses pipeline control
    if (!en) begin
      state_d  = state_q;
      drain_d  = drain_q;
      stall    = 1'b0;
      bubble   = 1'b0;
      flush    = 1'b0;
      lu_stall = 1'b0;
    end
    pc_en  = en && !stall && !halting;
    halted = (state_q == StHalted);
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (en) begin
      if (lu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_load_pc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// against a pipeline-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W     = 16;
  localparam int DRAIN_CYC = 2;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [4:0]       id_req_a, id_req_b, id_req_w;
  logic             id_use_a, id_use_b, id_w_en, id_is_load;
  logic             ex_load_pc, ex_halt;
  logic             stall, bubble, flush, wb_byp_a, wb_byp_b, pc_en, halted;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .id_req_a   (id_req_a),
    .id_req_b   (id_req_b),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_w_en    (id_w_en),
    .id_req_w   (id_req_w),
    .id_is_load (id_is_load),
    .ex_load_pc (ex_load_pc),
    .ex_halt    (ex_halt),
    .stall      (stall),
    .bubble     (bubble),
    .flush      (flush),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .wb_byp_a   (wb_byp_a),
    .wb_byp_b   (wb_byp_b),
    .pc_en      (pc_en),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { bit v; int rd; bit ld; } slot_t;
  slot_t pipe[3];           // 0 = EX, 1 = DM, 2 = WB
  int    m_mode;            // 0 running, 1 draining, 2 halted
  int    m_drained, m_sc, m_fc;
  bit    e_stall, e_bubble, e_flush, e_lustall, e_byp_a, e_byp_b, e_pc_en, e_halted;
  bit [1:0] e_fwd_a, e_fwd_b;

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0};
    m_mode = 0; m_drained = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic bit [1:0] redirect(input bit use_it, input int rs);
    if (!use_it || rs == 0) return 2'd0;
    if (pipe[0].v && pipe[0].rd == rs) return 2'd1;
    if (pipe[1].v && pipe[1].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_eval();
    bit lu;
    lu = (m_mode == 0) && pipe[0].v && pipe[0].ld &&
         ((id_use_a && int'(id_req_a) == pipe[0].rd) || (id_use_b && int'(id_req_b) == pipe[0].rd));
    e_flush   = en && (m_mode == 1 || (m_mode == 0 && (ex_load_pc || ex_halt)));
    e_lustall = en && lu && !e_flush;
    e_stall   = e_lustall || (en && m_mode == 2);
    e_bubble  = e_flush || e_lustall;
    e_pc_en   = en && !e_stall && m_mode == 0 && !ex_halt;
    e_fwd_a   = redirect(id_use_a, int'(id_req_a));
    e_fwd_b   = redirect(id_use_b, int'(id_req_b));
    e_byp_a   = id_use_a && id_req_a != 0 && pipe[2].v && pipe[2].rd == int'(id_req_a);
    e_byp_b   = id_use_b && id_req_b != 0 && pipe[2].v && pipe[2].rd == int'(id_req_b);
    e_halted  = (m_mode == 2);
  endtask

  // Applies one clock edge to the model, using the outputs from model_eval
  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (e_lustall && m_sc < 65535) m_sc++;
      if (ex_load_pc && m_fc < 65535) m_fc++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e_bubble) pipe[0] = '{0, 0, 0};
      else pipe[0] = '{id_w_en && id_req_w != 0, int'(id_req_w), id_is_load};
      if (m_mode == 0 && ex_halt) begin
        m_mode = 1; m_drained = 0;
      end else if (m_mode == 1) begin
        m_drained++;
        if (m_drained >= DRAIN_CYC) m_mode = 2;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit ua, input int a, input bit ub, input int b,
                        input bit we, input int w, input bit ld);
    id_use_a = ua; id_req_a = 5'(a); id_use_b = ub; id_req_b = 5'(b);
    id_w_en = we; id_req_w = 5'(w); id_is_load = ld;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; ex_load_pc = 1'b0; ex_halt = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({stall, bubble, flush, fwd_a, fwd_b, wb_byp_a, wb_byp_b, halted} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0", {stall, bubble, flush, fwd_a, fwd_b,
               wb_byp_a, wb_byp_b, halted});
    end
    tests_run++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    tests_run++;
    if (pc_en !== 1'b1) begin tests_failed++; $display("FAIL reset_pc_en: got %b want 1", pc_en); end
    en = 1'b0;
    #1;
    tests_run++;
    if (pc_en !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_en_off: got %b want 0", pc_en); end
    tick();
  endtask

  task automatic test_forward_ex();
    do_reset();
    set_id(0, 0, 0, 0, 1, 1, 0);      // addi $1
    tick();
    set_id(1, 1, 1, 1, 1, 2, 0);      // add $2,$1,$1
    @(negedge clk);
    tests_run++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd1 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_ex: got a=%0d b=%0d stall=%b want 1 1 0", fwd_a, fwd_b, stall);
    end
    tick();
    tests_run++;
    if (stall_cnt !== 0) begin tests_failed++; $display("FAIL fwd_ex_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 1, 3, 1);      // lw $3
    tick();
    set_id(1, 3, 1, 0, 1, 4, 0);      // add $4,$3,$0
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || bubble !== 1'b1 || pc_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_stall: got stall=%b bubble=%b pc_en=%b want 1 1 0", stall, bubble, pc_en);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || bubble !== 1'b0 || fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      tests_failed++;
      $display("FAIL lu_after: got stall=%b bubble=%b a=%0d b=%0d want 0 0 2 0",
               stall, bubble, fwd_a, fwd_b);
    end
    tests_run++;
    if (stall_cnt !== 1) begin tests_failed++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_wb_bypass();
    do_reset();
    set_id(0, 0, 0, 0, 1, 5, 0);      // writer of $5
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    set_id(1, 5, 1, 6, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (wb_byp_a !== 1'b1 || fwd_a !== 2'd0 || wb_byp_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL wb_byp: got byp_a=%b fwd_a=%0d byp_b=%b want 1 0 0", wb_byp_a, fwd_a, wb_byp_b);
    end
    do_reset();
    set_id(0, 0, 0, 0, 1, 0, 1);      // lw $0
    tick();
    set_id(1, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    tests_run++;
    if ({fwd_a, fwd_b, wb_byp_a, wb_byp_b, stall} !== 7'b0) begin
      tests_failed++;
      $display("FAIL zero_reg: got %b want 0", {fwd_a, fwd_b, wb_byp_a, wb_byp_b, stall});
    end
    tick();
  endtask

  task automatic test_flush_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 1, 6, 1);      // lw $6
    tick();
    set_id(1, 6, 0, 0, 1, 7, 0);      // reader of $6 writing $7, killed by the branch
    ex_load_pc = 1'b1;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b1 || stall !== 1'b0 || bubble !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_lu: got flush=%b stall=%b bubble=%b want 1 0 1", flush, stall, bubble);
    end
    tick();
    ex_load_pc = 1'b0;
    set_id(1, 6, 1, 7, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (fwd_a !== 2'd2 || fwd_b !== 2'd0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_sb_ex: got a=%0d b=%0d stall=%b want 2 0 0", fwd_a, fwd_b, stall);
    end
    tests_run++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      tests_failed++;
      $display("FAIL flush_cnt: got f=%0d s=%0d want 1 0", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    ex_halt = 1'b1;                   // cycle N
    @(negedge clk);
    tests_run++;
    if (pc_en !== 1'b0 || flush !== 1'b1 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_n: got pc_en=%b flush=%b halted=%b want 0 1 0", pc_en, flush, halted);
    end
    tick();
    ex_halt = 1'b0;
    for (int c = 1; c <= DRAIN_CYC; c++) begin
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b0 || pc_en !== 1'b0 || flush !== 1'b1) begin
        tests_failed++;
        $display("FAIL halt_drain%0d: got halted=%b pc_en=%b flush=%b want 0 0 1",
                 c, halted, pc_en, flush);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b1 || stall !== 1'b1 || pc_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_held%0d: got halted=%b stall=%b pc_en=%b want 1 1 0",
                 c, halted, stall, pc_en);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (halted !== 1'b0 || pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_rst: got halted=%b pc_en=%b want 0 1", halted, pc_en);
    end
    tick();
  endtask

  task automatic test_en_freeze();
    do_reset();
    set_id(0, 0, 0, 0, 1, 3, 1);      // lw $3
    tick();
    set_id(1, 3, 1, 0, 1, 4, 0);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (stall !== 1'b0 || bubble !== 1'b0 || pc_en !== 1'b0 || fwd_a !== 2'd1 ||
          stall_cnt !== 0) begin
        tests_failed++;
        $display("FAIL en_freeze%0d: got stall=%b bubble=%b pc_en=%b a=%0d cnt=%0d want 0 0 0 1 0",
                 c, stall, bubble, pc_en, fwd_a, stall_cnt);
      end
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || bubble !== 1'b1) begin
      tests_failed++;
      $display("FAIL en_resume: got stall=%b bubble=%b want 1 1", stall, bubble);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== 1 || fwd_a !== 2'd2 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_after: got cnt=%0d a=%0d stall=%b want 1 2 0", stall_cnt, fwd_a, stall);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst        = ($urandom_range(0, 99) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
      en         = ($urandom_range(0, 9) != 0);
      ex_load_pc = ($urandom_range(0, 7) == 0);
      ex_halt    = ($urandom_range(0, 59) == 0);
      set_id($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 2) == 0);
      @(negedge clk);
      model_eval();
      tests_run++;
      if ({stall, bubble, flush, fwd_a, fwd_b, wb_byp_a, wb_byp_b, pc_en, halted} !==
          {e_stall, e_bubble, e_flush, e_fwd_a, e_fwd_b, e_byp_a, e_byp_b, e_pc_en, e_halted}) begin
        tests_failed++;
        $display("FAIL rnd_outputs cyc %0d: got %b want %b (stall,bubble,flush,fa,fb,ba,bb,pc,halt)",
                 cyc, {stall, bubble, flush, fwd_a, fwd_b, wb_byp_a, wb_byp_b, pc_en, halted},
                 {e_stall, e_bubble, e_flush, e_fwd_a, e_fwd_b, e_byp_a, e_byp_b, e_pc_en, e_halted});
      end
      tests_run++;
      if (int'(stall_cnt) != m_sc || int'(flush_cnt) != m_fc) begin
        tests_failed++;
        $display("FAIL rnd_counters cyc %0d: got %0d/%0d want %0d/%0d",
                 cyc, stall_cnt, flush_cnt, m_sc, m_fc);
      end
      @(posedge clk);
      model_clock();
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward_ex();
    test_load_use();
    test_wb_bypass();
    test_flush_load_use();
    test_halt();
    test_en_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
